mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//  Iterative multiply/divide sequencer beside the single-cycle ALU. Executes MIPS
//  MULT/MULTU/DIV/DIVU over WIDTH cycles and owns the HI/LO architectural registers.
//  Also services MTHI/MTLO. The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand width; one iteration per bit, so latency = WIDTH cycles
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
//  a      in   WIDTH  rs operand (multiplicand / dividend / MTHI,MTLO data)
//  b      in   WIDTH  rt operand (multiplier / divisor)
//  flush  in   1      abort in-flight operation (exception/branch squash)
//  busy   out  1      operation in progress; pipeline must stall MDU/MFHI/MFLO ops
//  done   out  1      one-cycle pulse: hi/lo just updated by MULT*/DIV*
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0. rst overrides all inputs.
//    rst mid-operation aborts the operation and clears hi and lo.
//  - States are IDLE and CALC.
//  - IDLE with start=1:
//    - MULT*/DIV*: latch a, b and op -> CALC, busy=1, count=0.
//    - MTHI: hi<=a at the edge; MTLO: lo<=a at the edge; no busy, no done.
//    - Other op codes: no effect.
//  - CALC: one iteration per edge. On iteration WIDTH-1 (edge WIDTH after the accepting
//    edge) hi/lo are written, state -> IDLE, busy=0, and done=1 for the following cycle.
//    busy is high for exactly WIDTH cycles.
//  - While done=1 the block is IDLE, so a new start is accepted in the done cycle.
//  - start while busy=1: ignored, not queued. hi and lo hold their old values during CALC.
//  - Multiply: shift-add on operand magnitudes.
//    - MULTU: unsigned 2*WIDTH product.
//    - MULT: signed; product negated at the end when sign(a)^sign(b).
//    - Result: {hi,lo} = product.
//  - Divide: restoring algorithm on magnitudes, giving lo=quotient and hi=remainder.
//    - DIV: quotient truncates toward zero; remainder takes the sign of a.
//    - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//    - b=0 (DIV or DIVU): hi=a, lo=all ones. Deterministic; no exception is raised.
//  - flush=1 in CALC: -> IDLE at the next edge, busy=0, no done, hi/lo unchanged.
//  - flush=1 in IDLE: start is ignored that cycle (flush wins, including MTHI/MTLO).
//  - Operands are captured at acceptance; a and b may change during CALC.
// CONFIGURATION
//  MDU_DIV_EN defined: divide datapath built; DIV/DIVU behave as above.
//  MDU_DIV_EN undefined: divider logic not instantiated.
//    - DIV/DIVU are treated as no-ops: not accepted, busy stays 0, no done,
//      hi/lo unchanged.
//    - MULT/MULTU/MTHI/MTLO are unaffected.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy=1 for 32 cycles, then done pulse;
//     hi=0xFFFFFFFE, lo=0x00000001.
//  2. MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
//  3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     DIVU a=7 b=0 -> hi=7, lo=0xFFFFFFFF.
//  4. MTHI a=0x1234 and start asserted mid-CALC:
//     - mid-CALC start ignored and no extra done;
//     - MTHI issued in IDLE -> hi=0x1234 the next cycle, busy stays 0.
//  5. MULT started, flush=1 at cycle 10 -> busy=0 next cycle, no done, hi/lo hold
//     their prior values. Repeat with rst at cycle 10 -> hi=lo=0.
//  6. Back-to-back: new MULTU start in the done cycle -> accepted, busy=1 the next
//     cycle. Build without MDU_DIV_EN: DIV start -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide sequencer owning the HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider for DIV/DIVU.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     bm;
  logic [2*WIDTH-1:0]   p, p_nxt, prod;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 neg;
  logic                 idle_req, md_op, sgn_op, accept, last;

`ifdef MDU_DIV_EN
  logic                 is_div, neg_r;
  logic [WIDTH-1:0]     al, q, r;
  logic [WIDTH:0]       div_t, div_d;
`endif

  assign idle_req = (state == IDLE) && start && !flush;
  assign sgn_op   = !op[2] && !op[0];
`ifdef MDU_DIV_EN
  assign md_op    = !op[2];
`else
  assign md_op    = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign accept   = idle_req && md_op;
  assign last     = (state == CALC) && !flush && (cnt == LAST);
  assign mag_a    = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign mag_b    = (sgn_op && b[WIDTH-1]) ? -b : b;
  assign busy     = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (flush || cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p holds {accumulator/remainder, multiplier/dividend-quotient}
  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, bm} : '0);
    p_nxt   = {mul_sum, p[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    div_t = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_d = div_t - {1'b0, bm};
    if (is_div) begin
      if (div_d[WIDTH])
        p_nxt = {div_t[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
      else
        p_nxt = {div_d[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end
`endif
    prod   = neg ? -p_nxt : p_nxt;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    q = p_nxt[WIDTH-1:0];
    r = p_nxt[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_lo = neg   ? -q : q;
      res_hi = neg_r ? -r : r;
      if (bm == '0) begin
        res_hi = al;
        res_lo = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= '0;
      bm     <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      al     <= '0;
`endif
    end else begin
      done <= last;
      if (accept) begin
        p      <= {{WIDTH{1'b0}}, mag_a};
        bm     <= mag_b;
        cnt    <= '0;
        neg    <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MDU_DIV_EN
        is_div <= op[1];
        neg_r  <= sgn_op && a[WIDTH-1];
        al     <= a;
`endif
      end else if (state == CALC) begin
        p   <= p_nxt;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (idle_req && op == OP_MTHI) begin
        hi <= a;
      end else if (idle_req && op == OP_MTLO) begin
        lo <= a;
      end
    end
  end

endmodule
